// File: rtl/bfloat16_div.sv
// bfloat16_div: iterative bfloat16 divider (a / b).
// A restoring divider produces one quotient bit per cycle over nine cycles,
// then a normalization cycle registers the packed result. Exponents wrap
// modulo 256 and the mantissa is truncated, matching the bfloat16 multiplier.
// Zero operands (exponent 0) give signed zero or signed infinity, and take the
// same latency as every other operation.

module bfloat16_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Operand fields captured at acceptance
    logic       sign;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] mb;

    // Divider working registers
    logic [9:0] r;
    logic [8:0] q;
    logic [3:0] cnt;

    // Combinational divider step and result packing
    logic       r_ge;
    logic [9:0] r_sub;
    logic [9:0] r_next;
    logic [7:0] exp_res;
    logic [6:0] mant_res;
    logic [15:0] result;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the ready output
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = DIV;
                end
            end
            DIV: begin
                if (cnt == 4'd0) begin
                    next_state = NORM;
                end
            end
            NORM: begin
                next_state = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One restoring-division step: subtract when possible, then shift left
    always_comb begin
        r_ge   = (r >= {2'b00, mb});
        r_sub  = r_ge ? (r - {2'b00, mb}) : r;
        r_next = r_sub << 1;
    end

    // Normalize the quotient and apply the zero-operand special cases
    always_comb begin
        // The low 8 bits of ea - eb + bias are all that reach the output,
        // so computing in 8 bits gives the same modulo-256 wrap.
        exp_res  = ea - eb + (q[8] ? 8'd127 : 8'd126);
        mant_res = q[8] ? q[7:1] : q[6:0];
        if (ea == 8'd0) begin
            result = {sign, 15'b0};
        end else if (eb == 8'd0) begin
            result = {sign, 8'hFF, 7'b0};
        end else begin
            result = {sign, exp_res, mant_res};
        end
    end

    // Datapath: operand capture, quotient iteration and output holding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            ea        <= 8'd0;
            eb        <= 8'd0;
            mb        <= 8'd0;
            r         <= 10'd0;
            q         <= 9'd0;
            cnt       <= 4'd0;
            out       <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= a[15] ^ b[15];
                        ea   <= a[14:7];
                        eb   <= b[14:7];
                        mb   <= {1'b1, b[6:0]};
                        r    <= {2'b00, 1'b1, a[6:0]};
                        q    <= 9'd0;
                        cnt  <= 4'd8;
                    end
                end
                DIV: begin
                    q <= {q[7:0], r_ge};
                    r <= r_next;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                NORM: begin
                    out       <= result;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfloat16_div.sv
// tb_bfloat16_div: scoreboard bench for bfloat16_div.
// The driver pushes the hand-computed quotient and acceptance cycle for each
// operation; a monitor on the falling edge checks latency, output stability
// under backpressure, and the result at every output handshake.

module tb_bfloat16_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;

    typedef struct {
        logic [15:0] result;
        int          accept_cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          cycle_cnt = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] held_out   = 16'h0000;

    bfloat16_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure latency from the acceptance edge
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: latency on rising out_valid, stability while held, result at handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 16'd1, 16'd0);
                end else begin
                    check("latency", 16'(cycle_cnt - exp_q[0].accept_cycle), 16'd10);
                end
                held_out = out;
            end
            if (out_valid && prev_valid) begin
                check("out_stable", out, held_out);
            end
            if (out_valid) begin
                check("in_ready_while_out", {15'd0, in_ready}, 16'd0);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check("result", out, exp_q[0].result);
                void'(exp_q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic apply_stimulus(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] expv);
        int waited = 0;
        while (!in_ready && waited < 60) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", {15'd0, in_ready}, 16'd1);
        end else begin
            a        = av;
            b        = bv;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            exp_q.push_back('{result: expv, accept_cycle: cycle_cnt});
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 60) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 16'h0000;
        b         = 16'h0000;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 16'h0000);
        check("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check("reset_in_ready", {15'd0, in_ready}, 16'd1);
        rst_n = 1'b1;

        // Ordinary quotients
        apply_stimulus(16'h3F80, 16'h3F80, 16'h3F80);
        apply_stimulus(16'h4040, 16'h4000, 16'h3FC0);
        apply_stimulus(16'hC0C0, 16'h4000, 16'hC040);
        apply_stimulus(16'h3F80, 16'h4040, 16'h3EAA);
        // Exponent wrap on overflow and underflow
        apply_stimulus(16'h7F00, 16'h0080, 16'h3E00);
        apply_stimulus(16'h0080, 16'h7F00, 16'h4100);
        // Zero operands
        apply_stimulus(16'h3F80, 16'h0000, 16'h7F80);
        apply_stimulus(16'h8000, 16'h4000, 16'h8000);
        apply_stimulus(16'h0000, 16'h0000, 16'h0000);
        drain();

        // Backpressure and ignored inputs while busy
        out_ready = 1'b0;
        apply_stimulus(16'h4040, 16'h4000, 16'h3FC0);
        a        = 16'h3F80;
        b        = 16'h4040;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("in_ready_busy", {15'd0, in_ready}, 16'd0);
        end
        begin
            int waited = 0;
            while (!out_valid && waited < 30) begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        check("out_valid_wait", {15'd0, out_valid}, 16'd1);
        repeat (6) @(posedge clk);
        #1;
        check("held_valid", {15'd0, out_valid}, 16'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_handshake", {15'd0, in_ready}, 16'd1);
        check("valid_after_handshake", {15'd0, out_valid}, 16'd0);
        repeat (12) @(posedge clk);
        #1;
        check("no_extra_output", {15'd0, out_valid}, 16'd0);

        // Reset in the middle of an operation
        a        = 16'h4040;
        b        = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_out", out, 16'h0000);
        check("midreset_out_valid", {15'd0, out_valid}, 16'd0);
        check("midreset_in_ready", {15'd0, in_ready}, 16'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("no_output_after_reset", {15'd0, out_valid}, 16'd0);
        apply_stimulus(16'h4000, 16'h3F80, 16'h4000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
